// File: rtl/multiply_pipeline_pkg.sv
// Shared definitions for multiply_pipeline: parameter defaults, the stage record
// and the product narrowing function (shift, then extend, truncate or clamp).
package multiply_pkg;

    localparam int unsigned ARGW_DEFAULT   = 16;
    localparam int unsigned STAGES_DEFAULT = 2;
    // Working width for narrowing; products up to 126 bits are supported.
    localparam int unsigned FIT_W          = 128;

    typedef struct packed {
        logic             valid;
        logic [FIT_W-1:0] data;
    } stage_t;

    // product must already be sign/zero-extended to FIT_W by the caller.
    function automatic logic [FIT_W-1:0] fit(input logic [FIT_W-1:0] product,
                                             input int unsigned     frac,
                                             input int unsigned     resw,
                                             input logic            is_signed,
                                             input logic            sat);
        logic signed [FIT_W-1:0] s;
        logic signed [FIT_W-1:0] hi;
        logic signed [FIT_W-1:0] lo;
        logic        [FIT_W-1:0] one;
        one = FIT_W'(1);
        hi  = '0;
        lo  = '0;
        if (is_signed) s = $signed(product) >>> frac;
        else           s = $signed(product >> frac);
        if (sat && (resw < FIT_W - 1)) begin
            if (is_signed) begin
                hi = $signed((one << (resw - 1)) - one);
                lo = ~hi;
                if (s > hi)      s = hi;
                else if (s < lo) s = lo;
            end else begin
                hi = $signed((one << resw) - one);
                if (s > hi) s = hi;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/multiply_pipeline_if.sv
// Operand and result channels of multiply_pipeline; master drives operands,
// slave is the multiplier.
interface multiply_pipeline_if
    import multiply_pkg::*;
#(
    parameter int unsigned ARGW = ARGW_DEFAULT,
    parameter int unsigned RESW = 2 * ARGW
);
    logic [1:0]           arg_valid;
    logic [1:0][ARGW-1:0] arg_data;
    logic [1:0]           arg_ready;
    logic                 res_valid;
    logic [RESW-1:0]      res_data;
    logic                 res_ready;

    modport master (
        output arg_valid, arg_data, res_ready,
        input  arg_ready, res_valid, res_data
    );

    modport slave (
        input  arg_valid, arg_data, res_ready,
        output arg_ready, res_valid, res_data
    );
endinterface

// File: rtl/multiply_pipeline_pipe_stage.sv
// One valid/ready register slice; accepts a new entry whenever it is empty or
// its current entry drains this cycle, so bubbles collapse.
module pipe_stage #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         feed_valid,
    input  logic [W-1:0] feed_data,
    output logic         feed_ready_c,
    output logic         drain_valid,
    output logic [W-1:0] drain_data,
    input  logic         drain_ready
);
    assign feed_ready_c = !drain_valid || drain_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_valid <= 1'b0;
            drain_data  <= '0;
        end else if (feed_ready_c) begin
            drain_valid <= feed_valid;
            if (feed_valid) drain_data <= feed_data;
        end
    end
endmodule

// File: rtl/multiply_pipeline.sv
// Streaming two-operand multiplier with per-channel operand holds, STAGES-deep
// pipeline and fixed-point narrowing. Define MULTIPLY_PIPELINE_SATURATE_EN to clamp on overflow.
module multiply_pipeline
    import multiply_pkg::*;
#(
    parameter int unsigned ARGW   = ARGW_DEFAULT,
    parameter int unsigned RESW   = 2 * ARGW,
    parameter int unsigned FRAC   = 0,
    parameter int unsigned STAGES = STAGES_DEFAULT,
    parameter int unsigned SIGNED = 1
) (
    input logic               clk,
    input logic               rst,
    multiply_pipeline_if.slave bus
);
    localparam int unsigned PW = 2 * ARGW;
`ifdef MULTIPLY_PIPELINE_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [1:0][ARGW-1:0]   hold;
    logic [1:0]             held;
    logic [1:0]             capture_c;
    logic                   issue_c;
    logic [PW-1:0]          op_a;
    logic [PW-1:0]          op_b;
    logic [FIT_W-1:0]       fit_in;
    logic [STAGES:0]        stg_valid;
    logic [STAGES:0][PW-1:0] stg_data;
    logic [STAGES:0]        stg_ready;

    // A pair leaves the holds only when both are full and stage 0 can take it.
    assign issue_c       = held[0] && held[1] && stg_ready[0];
    assign bus.arg_ready = ~held | {2{issue_c}};
    assign capture_c     = bus.arg_valid & bus.arg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
            hold <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture_c[i]) begin
                    hold[i] <= bus.arg_data[i];
                    held[i] <= 1'b1;
                end else if (issue_c) begin
                    held[i] <= 1'b0;
                end
            end
        end
    end

    // Extend operands to product width so the low PW bits of the multiply are exact.
    if (SIGNED != 0) begin : g_sext
        assign op_a = {{ARGW{hold[0][ARGW-1]}}, hold[0]};
        assign op_b = {{ARGW{hold[1][ARGW-1]}}, hold[1]};
    end else begin : g_zext
        assign op_a = {{ARGW{1'b0}}, hold[0]};
        assign op_b = {{ARGW{1'b0}}, hold[1]};
    end

    assign stg_valid[0] = issue_c;
    assign stg_data[0]  = op_a * op_b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_stage #(.W(PW)) u_stage (
            .clk          (clk),
            .rst          (rst),
            .feed_valid   (stg_valid[k]),
            .feed_data    (stg_data[k]),
            .feed_ready_c (stg_ready[k]),
            .drain_valid  (stg_valid[k+1]),
            .drain_data   (stg_data[k+1]),
            .drain_ready  (stg_ready[k+1])
        );
    end

    assign stg_ready[STAGES] = bus.res_ready;
    assign bus.res_valid     = stg_valid[STAGES];

    // Narrowing sits after the last register: stable while stalled, no extra latency.
    if (SIGNED != 0) begin : g_fit_s
        assign fit_in = FIT_W'($signed(stg_data[STAGES]));
    end else begin : g_fit_u
        assign fit_in = FIT_W'(stg_data[STAGES]);
    end

    assign bus.res_data = RESW'(fit(fit_in, FRAC, RESW, SIGNED != 0, SAT_EN));
endmodule
